// File: rtl/hash_result_checker.sv
// Result checker at the hash pipeline output: pairs returned hashes with launched nonces,
// compares against the target and holds the first winner. Optional hit counter: HASH_CHECK_HITCNT_EN.
module hash_result_checker #(
  parameter int NONCE_W    = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Issue_I,
  input  logic [NONCE_W-1:0]  Nonce_I,
  input  logic                HVld_I,
  input  logic [0:7][31:0]    H_I,
  input  logic [0:7][31:0]    Target_I,
  input  logic                Clr_I,
  input  logic                Ack_I,
  output logic                Found_O,
  output logic [NONCE_W-1:0]  FoundNonce_O,
  output logic [0:7][31:0]    FoundHash_O,
  output logic [CNT_W-1:0]    Count_O,
  output logic                Err_O,
  output logic [15:0]         HitCnt_O
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_FOUND  = 1'b1
  } state_t;

  logic [NONCE_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic               push_s;
  logic               pop_s;
  logic               ovf_s;
  logic               udf_s;

  logic               s1_vld_r;
  logic [NONCE_W-1:0] s1_nonce_r;
  logic [0:7][31:0]   s1_hash_r;
  logic               hit_s;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               latch_s;
  logic               found_r;
  logic [NONCE_W-1:0] found_nonce_r;
  logic [0:7][31:0]   found_hash_r;
  logic [CNT_W-1:0]   count_r;
  logic               err_r;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

  // Tag FIFO handshake decode; a flush suppresses every push and pop.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    ovf_s  = 1'b0;
    udf_s  = 1'b0;
    if (Clr_I) begin
      push_s = 1'b0;
    end else begin
      pop_s  = HVld_I && !fifo_empty_s;
      udf_s  = HVld_I && fifo_empty_s;
      push_s = Issue_I && (!fifo_full_s || pop_s);
      ovf_s  = Issue_I && fifo_full_s && !pop_s;
    end
  end

  // Tag FIFO pointers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (Clr_I) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Tag FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge Clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r[AW-1:0]] <= Nonce_I;
  end

  // Stage 1: hash paired with its launch-order nonce.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_vld_r   <= 1'b0;
      s1_nonce_r <= '0;
      s1_hash_r  <= '0;
    end else if (Clr_I) begin
      s1_vld_r   <= 1'b0;
    end else begin
      s1_vld_r <= pop_s;
      if (pop_s) begin
        s1_nonce_r <= fifo_mem_r[rd_ptr_r[AW-1:0]];
        s1_hash_r  <= H_I;
      end
    end
  end

  // Checked-hash counter and sticky tag error.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else if (Clr_I) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if (pop_s)          count_r <= count_r + CNT_ONE;
      if (ovf_s || udf_s) err_r   <= 1'b1;
    end
  end

  // Packed [0:7] places word 0 in the MSBs, so this is the full 256-bit unsigned compare.
  assign hit_s = s1_vld_r && (s1_hash_r <= Target_I);

  // Stage 2: search/found control.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    if (Clr_I) begin
      state_nxt_s = ST_SEARCH;
    end else begin
      case (state_r)
        ST_SEARCH: begin
          if (hit_s) begin
            state_nxt_s = ST_FOUND;
            latch_s     = 1'b1;
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end
        ST_FOUND: begin
          if (Ack_I) begin
            state_nxt_s = ST_SEARCH;
          end else begin
            state_nxt_s = ST_FOUND;
          end
        end
        default: state_nxt_s = ST_SEARCH;
      endcase
    end
  end

  // State register and winner latch.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r       <= ST_SEARCH;
      found_r       <= 1'b0;
      found_nonce_r <= '0;
      found_hash_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      found_r <= (state_nxt_s == ST_FOUND);
      if (latch_s) begin
        found_nonce_r <= s1_nonce_r;
        found_hash_r  <= s1_hash_r;
      end
    end
  end

`ifdef HASH_CHECK_HITCNT_EN
  logic [15:0] hit_cnt_r;

  // Saturating count of every stage-2 hit, including those discarded while a winner is held.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hit_cnt_r <= 16'h0000;
    end else if (Clr_I) begin
      hit_cnt_r <= 16'h0000;
    end else if (hit_s && (hit_cnt_r != 16'hFFFF)) begin
      hit_cnt_r <= hit_cnt_r + 16'h0001;
    end
  end

  assign HitCnt_O = hit_cnt_r;
`else
  assign HitCnt_O = 16'h0000;
`endif

  assign Found_O      = found_r;
  assign FoundNonce_O = found_nonce_r;
  assign FoundHash_O  = found_hash_r;
  assign Count_O      = count_r;
  assign Err_O        = err_r;

endmodule

// File: tb/tb_hash_result_checker.sv
// Self-checking bench for hash_result_checker: directed scenarios plus random traffic
// against a queue-based reference model, with a scoreboard for latched winners.
module tb_hash_result_checker;

  typedef logic [0:7][31:0] hash_t;
  typedef struct packed {
    logic [31:0] n;
    hash_t       h;
  } exp_t;

  localparam int DEPTH = 16;

  logic        Clk, Rst, Issue_I, HVld_I, Clr_I, Ack_I;
  logic [31:0] Nonce_I;
  hash_t       H_I, Target_I;
  logic        Found_O, Err_O;
  logic [31:0] FoundNonce_O, Count_O;
  hash_t       FoundHash_O;
  logic [15:0] HitCnt_O;

  hash_result_checker #(.NONCE_W(32), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Issue_I(Issue_I), .Nonce_I(Nonce_I), .HVld_I(HVld_I),
    .H_I(H_I), .Target_I(Target_I), .Clr_I(Clr_I), .Ack_I(Ack_I),
    .Found_O(Found_O), .FoundNonce_O(FoundNonce_O), .FoundHash_O(FoundHash_O),
    .Count_O(Count_O), .Err_O(Err_O), .HitCnt_O(HitCnt_O)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vecs  = 0;
  int fails = 0;

  // reference model state
  logic [31:0] tagq[$];
  exp_t        expq[$];
  logic        pend_v = 1'b0;
  logic [31:0] pend_n = 32'h0;
  hash_t       pend_h = '0;
  logic        m_found = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_err = 1'b0;
  logic [15:0] m_hits = 16'h0;
  logic [31:0] m_last_n = 32'h0;
  hash_t       m_last_h = '0;
  logic        found_prev = 1'b0;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // lexicographic word compare, word 0 most significant
  function automatic logic is_hit(input hash_t h, input hash_t t);
    for (int i = 0; i < 8; i++) begin
      if (h[i] < t[i]) return 1'b1;
      if (h[i] > t[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic hash_t mk(input logic [31:0] w0);
    hash_t r;
    r = '1;
    r[0] = w0;
    return r;
  endfunction

  task automatic model_reset();
    tagq.delete(); expq.delete();
    pend_v = 1'b0; m_found = 1'b0; m_cnt = 32'h0; m_err = 1'b0; m_hits = 16'h0;
    m_last_n = 32'h0; m_last_h = '0;
  endtask

  // one clock: drive inputs, then advance the model with the same inputs after the edge
  task automatic step(input logic iss, input logic [31:0] nn, input logic hv, input hash_t hh,
                      input logic cl, input logic ak);
    logic hit;
    Issue_I = iss; Nonce_I = nn; HVld_I = hv; H_I = hh; Clr_I = cl; Ack_I = ak;
    @(posedge Clk);
    if (Rst) begin
      model_reset();
    end else if (cl) begin
      tagq.delete(); pend_v = 1'b0; m_found = 1'b0; m_cnt = 32'h0; m_err = 1'b0; m_hits = 16'h0;
    end else begin
      hit = pend_v && is_hit(pend_h, Target_I);
      if (hit && m_hits != 16'hFFFF) m_hits = m_hits + 16'h1;
      if (m_found) begin
        if (ak) m_found = 1'b0;
      end else if (hit) begin
        m_found = 1'b1; m_last_n = pend_n; m_last_h = pend_h;
        expq.push_back('{n: pend_n, h: pend_h});
      end
      pend_v = 1'b0;
      if (hv) begin
        if (tagq.size() == 0) m_err = 1'b1;
        else begin
          pend_n = tagq.pop_front(); pend_h = hh; pend_v = 1'b1; m_cnt = m_cnt + 32'h1;
        end
      end
      if (iss) begin
        if (tagq.size() < DEPTH) tagq.push_back(nn);
        else m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // per-cycle comparison against the model
  always @(negedge Clk) begin
    check("found", Found_O, m_found);
    check("count", Count_O, m_cnt);
    check("err", Err_O, m_err);
    check("found_nonce_hold", FoundNonce_O, m_last_n);
    check("found_hash_hold", FoundHash_O, m_last_h);
`ifdef HASH_CHECK_HITCNT_EN
    check("hitcnt", HitCnt_O, m_hits);
`else
    check("hitcnt_tied", HitCnt_O, 16'h0);
`endif
  end

  // scoreboard monitor: each new winner must match the next expected one
  always @(negedge Clk) begin
    exp_t e;
    if (Found_O && !found_prev) begin
      if (expq.size() == 0) begin
        check("sb_unexpected_found", 1'b1, 1'b0);
      end else begin
        e = expq.pop_front();
        check("sb_nonce", FoundNonce_O, e.n);
        check("sb_hash", FoundHash_O, e.h);
      end
    end
    found_prev = Found_O;
  end

  initial begin
    hash_t hh;
    logic [31:0] w0;
    Rst = 1'b1; Issue_I = 1'b0; Nonce_I = 32'h0; HVld_I = 1'b0; H_I = '0;
    Clr_I = 1'b0; Ack_I = 1'b0;
    Target_I = mk(32'h0000FFFF);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_found", Found_O, 1'b0);
    check("rst_nonce", FoundNonce_O, 32'h0);
    check("rst_hash", FoundHash_O, 256'h0);
    check("rst_count", Count_O, 32'h0);
    check("rst_err", Err_O, 1'b0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // exact boundary hit, nonce 5
    step(1'b1, 32'd5, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h0000FFFF), 1'b0, 1'b0);
    idle(3);
    check("boundary_nonce", FoundNonce_O, 32'd5);

    // miss then two hits, launch order pairing
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 10; i <= 12; i++) step(1'b1, 32'(i), 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h00010000), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h00000001), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h00000000), 1'b0, 1'b0);
    idle(3);
    check("order_nonce", FoundNonce_O, 32'd11);
    check("order_count", Count_O, 32'd3);

    // ack then a new winner
    step(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 32'd20, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h00000100), 1'b0, 1'b0);
    idle(3);
    check("ack_next_nonce", FoundNonce_O, 32'd20);

    // overflow: 17 issues, 17th dropped; drain shows nonce 115 last
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 32'(100 + i), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      step(1'b0, 32'h0, 1'b1, mk((i == 15) ? 32'h0 : 32'hFFFFFFFF), 1'b0, 1'b0);
    idle(3);
    check("ovf_last_nonce", FoundNonce_O, 32'd115);
    step(1'b0, 32'h0, 1'b1, mk(32'h0), 1'b0, 1'b0);
    idle(2);
    check("udf_count_held", Count_O, 32'd16);
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h0), 1'b0, 1'b0);
    idle(2);
    check("udf_err", Err_O, 1'b1);

    // clear mid-flight kills the pending hit
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(30 + i), 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h0), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 32'h0, 1'b1, mk(32'h0), 1'b0, 1'b0);
    idle(1);

    // winner plus a discarded hit, then async reset while found
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'd40, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'd41, 1'b1, mk(32'h10), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mk(32'h20), 1'b0, 1'b0);
    idle(3);
    #1 Rst = 1'b1;
    #1 check("async_rst_found", Found_O, 1'b0);
    check("async_rst_count", Count_O, 32'h0);
    model_reset();
    step(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
    Rst = 1'b0;

    // random traffic with a random low-order target
    for (int i = 1; i < 8; i++) Target_I[i] = $urandom;
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      for (int j = 1; j < 8; j++) hh[j] = $urandom;
      case ($urandom_range(0, 3))
        0: w0 = Target_I[0];
        1: w0 = $urandom_range(0, 32'h0000FFFF);
        default: w0 = 32'h00010000 + $urandom_range(0, 32'h0000FFFF);
      endcase
      hh[0] = w0;
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 4), hh,
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 6) == 0));
    end
    idle(4);
    check("sb_drained", 32'(expq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
